// File: rtl/irq_arbiter_pkg.sv
// Shared types and helpers for the interrupt arbiter.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

  localparam int unsigned ADR_W         = 12;
  localparam int unsigned ID_MAX_W      = 4;
  localparam logic [11:0] ISR_BASE_DEF  = 12'h100;
  localparam int unsigned VEC_SHIFT_DEF = 2;

  // Vector address for a source index; wraps modulo 4096.
  function automatic logic [11:0] vec_addr(input logic [11:0] base,
                                           input logic [3:0]  id,
                                           input int unsigned shift);
    logic [31:0] off;
    off = 32'(id) << shift;
    return 12'(32'(base) + off);
  endfunction

endpackage

// File: rtl/irq_arbiter_if.sv
// Bus between the core-side interrupt logic and the arbiter.
interface irq_arbiter_if #(
  parameter int unsigned N_SRC = 8
);
  localparam int unsigned ID_W = $clog2(N_SRC);

  logic [N_SRC-1:0] irq_src;
  logic             IEN_d;
  logic             IOF_d;
  logic             RTI_d;
  logic             irq_ack;
  logic             mask_we;
  logic [N_SRC-1:0] mask_wdata;
  logic             IRQ;
  logic [11:0]      ISR_adr;
  logic [ID_W-1:0]  irq_id;
  logic [N_SRC-1:0] pending;
  logic             in_service;

  // Core / interrupt-unit side.
  modport master (
    output irq_src, IEN_d, IOF_d, RTI_d, irq_ack, mask_we, mask_wdata,
    input  IRQ, ISR_adr, irq_id, pending, in_service
  );

  // Arbiter side.
  modport slave (
    input  irq_src, IEN_d, IOF_d, RTI_d, irq_ack, mask_we, mask_wdata,
    output IRQ, ISR_adr, irq_id, pending, in_service
  );

endinterface

// File: rtl/irq_arbiter_prio_enc.sv
// Lowest-index-first priority encoder.
module irq_prio_enc #(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic [N-1:0]     req,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  // Scan from the top so the lowest set index is written last.
  always_comb begin
    idx = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

  assign valid = |req;

endmodule

// File: rtl/irq_arbiter.sv
// Edge-latching interrupt arbiter with single in-service tracking.
module irq_arbiter
  import irq_pkg::*;
#(
  parameter int unsigned N_SRC     = 8,
  parameter logic [11:0] ISR_BASE  = ISR_BASE_DEF,
  parameter int unsigned VEC_SHIFT = VEC_SHIFT_DEF
) (
  input  logic          clock,
  input  logic          reset,
  irq_arbiter_if.slave  bus
);

  localparam int unsigned ID_W = $clog2(N_SRC);

  irq_state_t       state_q, state_d;
  logic [N_SRC-1:0] src_q, src_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic             ien_q, ien_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [11:0]      adr_q, adr_d;
  logic             irq_q, irq_d;
  logic             in_service_q, in_service_d;

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] clr;
  logic             win_valid;
  logic [ID_W-1:0]  win_idx;

  assign rise     = bus.irq_src & ~src_q;
  assign eligible = pending_q & ~mask_q;

  irq_prio_enc #(
    .N     (N_SRC),
    .IDX_W (ID_W)
  ) u_prio (
    .req   (eligible),
    .valid (win_valid),
    .idx   (win_idx)
  );

  // Next-state, pending/mask/enable updates and registered output decode.
  always_comb begin
    state_d = state_q;
    src_d   = bus.irq_src;
    mask_d  = bus.mask_we ? bus.mask_wdata : mask_q;
    id_d    = id_q;
    adr_d   = adr_q;
    clr     = '0;

    // IOF beats IEN when both arrive together.
    if (bus.IOF_d)      ien_d = 1'b0;
    else if (bus.IEN_d) ien_d = 1'b1;
    else                ien_d = ien_q;

    case (state_q)
      IDLE: begin
        if (ien_q && win_valid) begin
          state_d = REQ;
          id_d    = win_idx;
          adr_d   = vec_addr(ISR_BASE, 4'(win_idx), VEC_SHIFT);
        end
      end
      REQ: begin
        if (bus.irq_ack) begin
          state_d = SERVICE;
          clr     = N_SRC'(1) << id_q;
        end else if (!ien_d) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (bus.RTI_d) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A fresh edge on the acknowledged source survives the clear.
    pending_d    = (pending_q & ~clr) | rise;
    irq_d        = (state_d == REQ);
    in_service_d = (state_d == SERVICE);
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      src_q        <= '0;
      pending_q    <= '0;
      mask_q       <= '1;
      ien_q        <= 1'b0;
      id_q         <= '0;
      adr_q        <= ISR_BASE;
      irq_q        <= 1'b0;
      in_service_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      ien_q        <= ien_d;
      id_q         <= id_d;
      adr_q        <= adr_d;
      irq_q        <= irq_d;
      in_service_q <= in_service_d;
    end
  end

  assign bus.IRQ        = irq_q;
  assign bus.in_service = in_service_q;
  assign bus.ISR_adr    = adr_q;
  assign bus.irq_id     = id_q;
  assign bus.pending    = pending_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed, table-driven bench for irq_arbiter.
module tb_irq_arbiter;

  logic clk;
  logic rst;
  logic rst2;

  irq_arbiter_if #(.N_SRC(8)) bus ();
  irq_arbiter_if #(.N_SRC(8)) bus2 ();

  irq_arbiter #(
    .N_SRC     (8),
    .ISR_BASE  (12'h100),
    .VEC_SHIFT (2)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  irq_arbiter #(
    .N_SRC     (8),
    .ISR_BASE  (12'hFFC),
    .VEC_SHIFT (2)
  ) dut_wrap (
    .clock (clk),
    .reset (rst2),
    .bus   (bus2.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst;
    logic [7:0]  src;
    logic        ien;
    logic        iof;
    logic        rti;
    logic        ack;
    logic        mwe;
    logic [7:0]  mwd;
    logic        e_irq;
    logic        e_isv;
    logic [2:0]  e_id;
    logic [11:0] e_adr;
    logic [7:0]  e_pend;
  } vec_t;

  localparam int NV = 45;
  vec_t tbl [NV];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic [7:0] s, input logic en, input logic of,
                              input logic rt, input logic ak, input logic we, input logic [7:0] wd,
                              input logic ei, input logic es, input logic [2:0] eid,
                              input logic [11:0] ea, input logic [7:0] ep);
    vec_t v;
    v.rst = r; v.src = s; v.ien = en; v.iof = of; v.rti = rt; v.ack = ak;
    v.mwe = we; v.mwd = wd; v.e_irq = ei; v.e_isv = es; v.e_id = eid;
    v.e_adr = ea; v.e_pend = ep;
    return v;
  endfunction

  task automatic idle_inputs();
    bus.irq_src = '0; bus.IEN_d = 0; bus.IOF_d = 0; bus.RTI_d = 0;
    bus.irq_ack = 0; bus.mask_we = 0; bus.mask_wdata = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    //          rst src   ien iof rti ack mwe mwd    irq isv id adr     pend
    tbl[0]  = mk(0, 8'h00, 0, 0, 0, 0, 1, 8'h00,  0, 0, 0, 12'h100, 8'h00);
    tbl[1]  = mk(0, 8'h08, 0, 0, 0, 0, 0, 8'h00,  0, 0, 0, 12'h100, 8'h08);
    tbl[2]  = mk(1, 8'h00, 0, 0, 0, 0, 0, 8'h00,  0, 0, 0, 12'h100, 8'h00);
    tbl[3]  = mk(0, 8'h00, 0, 0, 0, 0, 1, 8'h00,  0, 0, 0, 12'h100, 8'h00);
    tbl[4]  = mk(0, 8'h00, 1, 0, 0, 0, 0, 8'h00,  0, 0, 0, 12'h100, 8'h00);
    tbl[5]  = mk(0, 8'h24, 0, 0, 0, 0, 0, 8'h00,  0, 0, 0, 12'h100, 8'h24);
    tbl[6]  = mk(0, 8'h24, 0, 0, 0, 0, 0, 8'h00,  1, 0, 2, 12'h108, 8'h24);
    tbl[7]  = mk(0, 8'h24, 0, 0, 0, 1, 0, 8'h00,  0, 1, 2, 12'h108, 8'h20);
    tbl[8]  = mk(0, 8'h24, 0, 0, 0, 0, 0, 8'h00,  0, 1, 2, 12'h108, 8'h20);
    tbl[9]  = mk(0, 8'h24, 0, 0, 1, 0, 0, 8'h00,  0, 0, 2, 12'h108, 8'h20);
    tbl[10] = mk(0, 8'h24, 0, 0, 0, 0, 0, 8'h00,  1, 0, 5, 12'h114, 8'h20);
    tbl[11] = mk(0, 8'h24, 0, 0, 1, 0, 0, 8'h00,  1, 0, 5, 12'h114, 8'h20);
    tbl[12] = mk(0, 8'h24, 0, 0, 0, 1, 0, 8'h00,  0, 1, 5, 12'h114, 8'h00);
    tbl[13] = mk(0, 8'h24, 0, 0, 1, 0, 0, 8'h00,  0, 0, 5, 12'h114, 8'h00);
    tbl[14] = mk(0, 8'h00, 0, 0, 0, 1, 0, 8'h00,  0, 0, 5, 12'h114, 8'h00);
    tbl[15] = mk(0, 8'h10, 0, 0, 0, 0, 0, 8'h00,  0, 0, 5, 12'h114, 8'h10);
    tbl[16] = mk(0, 8'h10, 0, 0, 0, 0, 0, 8'h00,  1, 0, 4, 12'h110, 8'h10);
    tbl[17] = mk(0, 8'h10, 0, 1, 0, 0, 0, 8'h00,  0, 0, 4, 12'h110, 8'h10);
    tbl[18] = mk(0, 8'h10, 0, 0, 0, 0, 0, 8'h00,  0, 0, 4, 12'h110, 8'h10);
    tbl[19] = mk(0, 8'h10, 1, 0, 0, 0, 0, 8'h00,  0, 0, 4, 12'h110, 8'h10);
    tbl[20] = mk(0, 8'h10, 0, 0, 0, 0, 0, 8'h00,  1, 0, 4, 12'h110, 8'h10);
    tbl[21] = mk(0, 8'h10, 0, 0, 0, 1, 0, 8'h00,  0, 1, 4, 12'h110, 8'h00);
    tbl[22] = mk(0, 8'h10, 0, 0, 1, 0, 0, 8'h00,  0, 0, 4, 12'h110, 8'h00);
    tbl[23] = mk(0, 8'h10, 0, 0, 0, 0, 1, 8'h01,  0, 0, 4, 12'h110, 8'h00);
    tbl[24] = mk(0, 8'h11, 0, 0, 0, 0, 0, 8'h00,  0, 0, 4, 12'h110, 8'h01);
    tbl[25] = mk(0, 8'h11, 0, 0, 0, 0, 0, 8'h00,  0, 0, 4, 12'h110, 8'h01);
    tbl[26] = mk(0, 8'h11, 0, 0, 0, 0, 1, 8'h00,  0, 0, 4, 12'h110, 8'h01);
    tbl[27] = mk(0, 8'h11, 0, 0, 0, 0, 0, 8'h00,  1, 0, 0, 12'h100, 8'h01);
    tbl[28] = mk(0, 8'h11, 0, 0, 0, 1, 0, 8'h00,  0, 1, 0, 12'h100, 8'h00);
    tbl[29] = mk(0, 8'h11, 0, 0, 1, 0, 0, 8'h00,  0, 0, 0, 12'h100, 8'h00);
    tbl[30] = mk(0, 8'h02, 0, 0, 0, 0, 0, 8'h00,  0, 0, 0, 12'h100, 8'h02);
    tbl[31] = mk(0, 8'h02, 0, 0, 0, 0, 0, 8'h00,  1, 0, 1, 12'h104, 8'h02);
    tbl[32] = mk(0, 8'h02, 0, 0, 0, 1, 0, 8'h00,  0, 1, 1, 12'h104, 8'h00);
    tbl[33] = mk(0, 8'h02, 0, 0, 0, 0, 0, 8'h00,  0, 1, 1, 12'h104, 8'h00);
    tbl[34] = mk(0, 8'h02, 0, 0, 1, 0, 0, 8'h00,  0, 0, 1, 12'h104, 8'h00);
    tbl[35] = mk(0, 8'h02, 0, 0, 0, 0, 0, 8'h00,  0, 0, 1, 12'h104, 8'h00);
    tbl[36] = mk(0, 8'h02, 0, 0, 0, 0, 0, 8'h00,  0, 0, 1, 12'h104, 8'h00);
    tbl[37] = mk(0, 8'h00, 0, 0, 0, 0, 0, 8'h00,  0, 0, 1, 12'h104, 8'h00);
    tbl[38] = mk(0, 8'h02, 0, 0, 0, 0, 0, 8'h00,  0, 0, 1, 12'h104, 8'h02);
    tbl[39] = mk(0, 8'h02, 0, 0, 0, 0, 0, 8'h00,  1, 0, 1, 12'h104, 8'h02);
    tbl[40] = mk(0, 8'h00, 0, 0, 0, 0, 0, 8'h00,  1, 0, 1, 12'h104, 8'h02);
    tbl[41] = mk(0, 8'h02, 0, 0, 0, 1, 0, 8'h00,  0, 1, 1, 12'h104, 8'h02);
    tbl[42] = mk(0, 8'h02, 0, 0, 1, 0, 0, 8'h00,  0, 0, 1, 12'h104, 8'h02);
    tbl[43] = mk(0, 8'h02, 0, 0, 0, 0, 0, 8'h00,  1, 0, 1, 12'h104, 8'h02);
    tbl[44] = mk(0, 8'h02, 0, 0, 0, 1, 0, 8'h00,  0, 1, 1, 12'h104, 8'h00);

    rst  = 1'b1;
    rst2 = 1'b1;
    idle_inputs();
    bus2.irq_src = '0; bus2.IEN_d = 0; bus2.IOF_d = 0; bus2.RTI_d = 0;
    bus2.irq_ack = 0; bus2.mask_we = 0; bus2.mask_wdata = '0;
    @(negedge clk);
    @(negedge clk);

    check("reset irq",  32'(bus.IRQ),        32'd0);
    check("reset isv",  32'(bus.in_service), 32'd0);
    check("reset adr",  32'(bus.ISR_adr),    32'h100);
    check("reset id",   32'(bus.irq_id),     32'd0);
    check("reset pend", 32'(bus.pending),    32'h00);
    check("wrap reset adr", 32'(bus2.ISR_adr), 32'hFFC);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      rst            = tbl[i].rst;
      bus.irq_src    = tbl[i].src;
      bus.IEN_d      = tbl[i].ien;
      bus.IOF_d      = tbl[i].iof;
      bus.RTI_d      = tbl[i].rti;
      bus.irq_ack    = tbl[i].ack;
      bus.mask_we    = tbl[i].mwe;
      bus.mask_wdata = tbl[i].mwd;
      cyc();
      check($sformatf("v%0d irq", i),  32'(bus.IRQ),        32'(tbl[i].e_irq));
      check($sformatf("v%0d isv", i),  32'(bus.in_service), 32'(tbl[i].e_isv));
      check($sformatf("v%0d id", i),   32'(bus.irq_id),     32'(tbl[i].e_id));
      check($sformatf("v%0d adr", i),  32'(bus.ISR_adr),    32'(tbl[i].e_adr));
      check($sformatf("v%0d pend", i), 32'(bus.pending),    32'(tbl[i].e_pend));
    end

    // Asynchronous reset while in service takes effect before any clock edge.
    idle_inputs();
    bus.irq_src = 8'h02;
    rst = 1'b1;
    #1;
    check("async rst isv",  32'(bus.in_service), 32'd0);
    check("async rst irq",  32'(bus.IRQ),        32'd0);
    check("async rst pend", 32'(bus.pending),    32'h00);
    check("async rst adr",  32'(bus.ISR_adr),    32'h100);
    check("async rst id",   32'(bus.irq_id),     32'd0);
    cyc();
    rst = 1'b0;
    idle_inputs();

    // Mask is all ones after reset: an enabled edge must not request.
    bus.IEN_d = 1'b1;
    cyc();
    bus.IEN_d = 1'b0;
    bus.irq_src = 8'h40;
    cyc();
    cyc();
    check("mask rst irq",  32'(bus.IRQ),     32'd0);
    check("mask rst pend", 32'(bus.pending), 32'h40);
    bus.mask_we = 1'b1;
    bus.mask_wdata = 8'h00;
    cyc();
    bus.mask_we = 1'b0;
    check("unmask lat irq", 32'(bus.IRQ), 32'd0);
    cyc();
    check("unmask irq", 32'(bus.IRQ),     32'd1);
    check("unmask id",  32'(bus.irq_id),  32'd6);
    check("unmask adr", 32'(bus.ISR_adr), 32'h118);

    // Winner stays frozen in REQ despite a higher-priority edge and a mask write.
    bus.irq_src = 8'h41;
    bus.mask_we = 1'b1;
    bus.mask_wdata = 8'h40;
    cyc();
    bus.mask_we = 1'b0;
    check("freeze irq",  32'(bus.IRQ),     32'd1);
    check("freeze id",   32'(bus.irq_id),  32'd6);
    check("freeze pend", 32'(bus.pending), 32'h41);

    // Vector address wraps modulo 4096.
    rst2 = 1'b0;
    bus2.mask_we = 1'b1;
    bus2.mask_wdata = 8'h00;
    bus2.IEN_d = 1'b1;
    cyc();
    bus2.mask_we = 1'b0;
    bus2.IEN_d = 1'b0;
    bus2.irq_src = 8'h02;
    cyc();
    check("wrap pend", 32'(bus2.pending), 32'h02);
    cyc();
    check("wrap irq", 32'(bus2.IRQ),     32'd1);
    check("wrap id",  32'(bus2.irq_id),  32'd1);
    check("wrap adr", 32'(bus2.ISR_adr), 32'h000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/irq_arbiter.md
# irq_arbiter

Multi-source interrupt front end for the 12-bit RISC core. Collects up to `N_SRC` edge-triggered interrupt lines, latches them as pending, applies a mask and the core's global enable (IEN/IOF), picks the highest-priority unmasked source, and presents a single request plus ISR vector to the existing interrupt unit. It tracks one in-service interrupt until the core retires it with RTI. Nesting is not supported.

## Interface
- `N_SRC`, 8: number of interrupt sources (2..16).
- `ISR_BASE`, 12'h100: vector table base address.
- `VEC_SHIFT`, 2: log2 of vector stride in words.
- `clock`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `irq_src`  in  N_SRC  interrupt lines, synchronous to `clock`, rising-edge significant.
- `IEN_d`  in  1  decoded IEN instruction, 1-cycle pulse; sets global enable.
- `IOF_d`  in  1  decoded IOF instruction, 1-cycle pulse; clears global enable.
- `RTI_d`  in  1  decoded RTI instruction, 1-cycle pulse; ends service.
- `irq_ack`  in  1  interrupt unit has taken the branch to `ISR_adr`.
- `mask_we`  in  1  write strobe for the mask register.
- `mask_wdata`  in  N_SRC  new mask; 1 = source blocked.
- `IRQ`  out  1  request to the interrupt unit.
- `ISR_adr`  out  12  vector of the requested or in-service source.
- `irq_id`  out  clog2(N_SRC)  index of the requested or in-service source.
- `pending`  out  N_SRC  pending register, visible for debug and software polling.
- `in_service`  out  1  high while an ISR is running.

## Operation
- Registers: `src_q` (previous `irq_src`), `pending`, `mask`, `ien`, `state`, `id_q`, `adr_q`.
- Edge detect: `pending[i]` sets when `irq_src[i]==1 && src_q[i]==0`. A level held high sets it only once.
- Global enable: `IEN_d` sets `ien` and `IOF_d` clears it. If both arrive in the same cycle, `IOF_d` wins.
- Priority is fixed: lowest index wins among `pending & ~mask`.
- States:
  - IDLE: if `ien` and any eligible source, go to REQ and latch `id_q`/`adr_q` from the winner.
  - REQ: `IRQ=1`.
    - `irq_ack`: go to SERVICE and clear `pending[id_q]`. If a new edge on the same source arrives in that cycle, the set wins.
    - `ien` cleared (including by `IOF_d` in the same cycle) without `irq_ack`: return to IDLE; the pending bit is retained.
  - SERVICE: `in_service=1`. `RTI_d` returns to IDLE.
- `RTI_d` in IDLE or REQ is ignored. `irq_ack` outside REQ is ignored.
- The winner is frozen once in REQ. Mask writes or new higher-priority edges do not change `id_q` until the next arbitration.
- A mask write takes effect for the next IDLE arbitration. Pending bits are never cleared by masking.
- `ISR_adr = (ISR_BASE + (id_q << VEC_SHIFT))` truncated to 12 bits (wraps modulo 4096).
- Reset values:
  - `state`: IDLE.
  - `pending`, `src_q`, `ien`, `id_q`: 0.
  - `mask`: all 1s (all blocked).
  - `adr_q`: `ISR_BASE`.
  - Outputs: `IRQ=0`, `in_service=0`, `ISR_adr=ISR_BASE`, `irq_id=0`, `pending=0`.
- Reset mid-operation returns immediately to the reset values. Any request or service in progress is dropped.

## Timing
- Edge at `irq_src` sampled at edge n: `pending` is high after edge n.
- IDLE arbitration at edge n+1: `IRQ` is high after edge n+1. Minimum latency from source edge to `IRQ` is 2 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `irq_ack` sampled high at edge k: `IRQ` low and `in_service` high after edge k.
- `RTI_d` at edge k: IDLE after edge k. The next `IRQ` can come no earlier than after edge k+1.
- `IEN_d` pulse followed by an already-pending eligible source: `IRQ` 1 cycle after `ien` sets.

## Structure
- Package `irq_pkg`:
  - `irq_state_t` enum (IDLE, REQ, SERVICE).
  - Default values for `ISR_BASE` and `VEC_SHIFT`.
  - Function `vec_addr(id)` computing the vector address.
- Sub-module `irq_prio_enc`: parameterised lowest-index-first priority encoder with `valid` and `idx` outputs. Combinational. Instantiated once.

## Test plan
- Reset → all outputs at reset values. With `mask=0` and `ien=0`, a rising edge on `irq_src[3]` sets `pending=8'h08` and leaves `IRQ=0`.
- Pulse `IEN_d` with `mask=0`, then raise `irq_src[5]` and `irq_src[2]` on the same edge → `IRQ=1` after 2 cycles with `irq_id=2` and `ISR_adr=12'h108`. `irq_ack` → `pending=8'h20`, `in_service=1`. `RTI_d` → id 5 requested with `ISR_adr=12'h114`.
- In REQ for id 4, pulse `IOF_d` → `IRQ` drops next cycle and `pending[4]` stays 1. Pulse `IEN_d` → `IRQ` reasserts with id 4.
- Set `mask=8'h01` and raise `irq_src[0]` → no `IRQ`. Write `mask=0` → `IRQ` with id 0 one cycle after the write.
- Hold `irq_src[1]` high for 10 cycles → exactly one service. An edge on source 1 in the same cycle as `irq_ack` for id 1 leaves `pending[1]=1`.
- Assert `reset` while in SERVICE → `in_service=0`, `mask=8'hFF`, `pending=0` immediately. With `ISR_BASE=12'hFFC`, `VEC_SHIFT=2`, id 1 → `ISR_adr=12'h000` (wrap).
